// File: rtl/output_channel_buffer_bank_if.sv
// Writeback-enqueue and network-dequeue signal bundle for output_channel_buffer_bank.
// master = writeback/network side, slave = the buffer bank.
interface output_channel_buffer_bank_if #(
   parameter int unsigned NUM_OUTPUT_CHANNELS = 4,
   parameter int unsigned COUNT_WIDTH         = 3,
   parameter int unsigned TAG_WIDTH           = 3,
   parameter int unsigned WORD_WIDTH          = 32
);
   logic                                              enqueue_valid;
   logic [NUM_OUTPUT_CHANNELS-1:0]                    enqueue_oci;
   logic [TAG_WIDTH-1:0]                              enqueue_tag;
   logic [WORD_WIDTH-1:0]                             enqueue_data;
   logic [NUM_OUTPUT_CHANNELS-1:0][COUNT_WIDTH-1:0]   output_channel_counts;
   logic [NUM_OUTPUT_CHANNELS-1:0]                    output_channel_valid;
   logic [NUM_OUTPUT_CHANNELS-1:0][TAG_WIDTH-1:0]     output_channel_tags;
   logic [NUM_OUTPUT_CHANNELS-1:0][WORD_WIDTH-1:0]    output_channel_data;
   logic [NUM_OUTPUT_CHANNELS-1:0]                    output_channel_ready;
   logic [NUM_OUTPUT_CHANNELS-1:0]                    overflow_error;

   modport master (
      output enqueue_valid, enqueue_oci, enqueue_tag, enqueue_data, output_channel_ready,
      input  output_channel_counts, output_channel_valid, output_channel_tags,
             output_channel_data, overflow_error
   );

   modport slave (
      input  enqueue_valid, enqueue_oci, enqueue_tag, enqueue_data, output_channel_ready,
      output output_channel_counts, output_channel_valid, output_channel_tags,
             output_channel_data, overflow_error
   );
endinterface

// File: rtl/output_channel_buffer_bank.sv
// Per-output-channel FIFO bank: multicast enqueue from writeback, valid/ready dequeue to network.
// Optional sticky overflow flags under `TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN.
module output_channel_buffer_bank #(
   parameter int unsigned NUM_OUTPUT_CHANNELS = 4,
   parameter int unsigned FIFO_DEPTH          = 4,
   parameter int unsigned COUNT_WIDTH         = $clog2(FIFO_DEPTH + 1),
   parameter int unsigned TAG_WIDTH           = 3,
   parameter int unsigned WORD_WIDTH          = 32
) (
   input logic                         clock,
   input logic                         reset,
   output_channel_buffer_bank_if.slave bus
);
   localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FIFO_DEPTH);

   logic [NUM_OUTPUT_CHANNELS-1:0]                  deq;
   logic [NUM_OUTPUT_CHANNELS-1:0]                  enq_req;
   logic [NUM_OUTPUT_CHANNELS-1:0]                  enq_acc;
   logic [NUM_OUTPUT_CHANNELS-1:0][COUNT_WIDTH-1:0] count;
   logic [NUM_OUTPUT_CHANNELS-1:0][PTR_WIDTH-1:0]   rd_ptr;
   logic [NUM_OUTPUT_CHANNELS-1:0][PTR_WIDTH-1:0]   wr_ptr;
   logic [TAG_WIDTH-1:0]                            tag_mem  [NUM_OUTPUT_CHANNELS][FIFO_DEPTH];
   logic [WORD_WIDTH-1:0]                           data_mem [NUM_OUTPUT_CHANNELS][FIFO_DEPTH];

   // A full channel still accepts when its head leaves in the same cycle.
   always_comb begin
      deq     = '0;
      enq_req = '0;
      enq_acc = '0;
      for (int unsigned i = 0; i < NUM_OUTPUT_CHANNELS; i++) begin
         deq[i]     = (count[i] != '0) && bus.output_channel_ready[i];
         enq_req[i] = bus.enqueue_valid && bus.enqueue_oci[i];
         enq_acc[i] = enq_req[i] && ((count[i] < FULL_COUNT) || deq[i]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_OUTPUT_CHANNELS; i++) begin
            if (enq_acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (deq[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
            if (enq_acc[i] && !deq[i])
               count[i] <= count[i] + 1'b1;
            else if (!enq_acc[i] && deq[i])
               count[i] <= count[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < NUM_OUTPUT_CHANNELS; i++) begin
         if (enq_acc[i]) begin
            tag_mem[i][wr_ptr[i]]  <= bus.enqueue_tag;
            data_mem[i][wr_ptr[i]] <= bus.enqueue_data;
         end
      end
   end

   // Outputs depend only on registered state; heads read as zero while empty.
   always_comb begin
      bus.output_channel_counts = '0;
      bus.output_channel_valid  = '0;
      bus.output_channel_tags   = '0;
      bus.output_channel_data   = '0;
      for (int unsigned i = 0; i < NUM_OUTPUT_CHANNELS; i++) begin
         bus.output_channel_counts[i] = count[i];
         bus.output_channel_valid[i]  = (count[i] != '0);
         if (count[i] != '0) begin
            bus.output_channel_tags[i] = tag_mem[i][rd_ptr[i]];
            bus.output_channel_data[i] = data_mem[i][rd_ptr[i]];
         end
      end
   end

`ifdef TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN
   logic [NUM_OUTPUT_CHANNELS-1:0] overflow;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) overflow <= '0;
      else        overflow <= overflow | (enq_req & ~enq_acc);
   end

   assign bus.overflow_error = overflow;
`else
   assign bus.overflow_error = '0;
`endif
endmodule

// File: tb/tb_output_channel_buffer_bank.sv
// Self-checking bench for output_channel_buffer_bank: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_output_channel_buffer_bank;
   localparam int unsigned N  = 4;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = 3;
   localparam int unsigned TW = 3;
   localparam int unsigned WW = 32;
`ifdef TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN
   localparam logic [N-1:0] OVF_EXP = 4'b0100;
`else
   localparam logic [N-1:0] OVF_EXP = 4'b0000;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   output_channel_buffer_bank_if #(
      .NUM_OUTPUT_CHANNELS(N), .COUNT_WIDTH(CW), .TAG_WIDTH(TW), .WORD_WIDTH(WW)
   ) bus ();

   output_channel_buffer_bank #(
      .NUM_OUTPUT_CHANNELS(N), .FIFO_DEPTH(D), .COUNT_WIDTH(CW), .TAG_WIDTH(TW), .WORD_WIDTH(WW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [WW-1:0] data;
   } entry_t;

   entry_t       q [N][$];
   logic [N-1:0] exp_ovf = '0;
   int           vectors = 0;
   int           miscompares = 0;
   bit           checking = 0;
   bit           m_deq, m_acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain queues, one per channel.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) q[i].delete();
         exp_ovf = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            m_deq = (q[i].size() != 0) && bus.output_channel_ready[i];
            m_acc = bus.enqueue_valid && bus.enqueue_oci[i] && ((q[i].size() < D) || m_deq);
            if (m_deq) void'(q[i].pop_front());
            if (m_acc) q[i].push_back({bus.enqueue_tag, bus.enqueue_data});
`ifdef TIA_OUTPUT_CHANNEL_OVERFLOW_CHECK_EN
            if (bus.enqueue_valid && bus.enqueue_oci[i] && !m_acc) exp_ovf[i] = 1'b1;
`endif
         end
      end
   end

   always @(negedge clock) begin
      if (checking) begin
         for (int i = 0; i < N; i++) begin
            check($sformatf("count%0d", i), 64'(bus.output_channel_counts[i]), 64'(q[i].size()));
            check($sformatf("valid%0d", i), 64'(bus.output_channel_valid[i]), 64'(q[i].size() != 0));
            if (q[i].size() != 0) begin
               check($sformatf("tag%0d", i), 64'(bus.output_channel_tags[i]), 64'(q[i][0].tag));
               check($sformatf("data%0d", i), 64'(bus.output_channel_data[i]), 64'(q[i][0].data));
            end
         end
         check("overflow", 64'(bus.overflow_error), 64'(exp_ovf));
      end
   end

   task automatic step(input logic v, input logic [N-1:0] oci, input logic [TW-1:0] tag,
                       input logic [WW-1:0] data, input logic [N-1:0] rdy);
      bus.enqueue_valid        = v;
      bus.enqueue_oci          = oci;
      bus.enqueue_tag          = tag;
      bus.enqueue_data         = data;
      bus.output_channel_ready = rdy;
      @(negedge clock);
   endtask

   initial begin
      bus.enqueue_valid        = 1'b0;
      bus.enqueue_oci          = '0;
      bus.enqueue_tag          = '0;
      bus.enqueue_data         = '0;
      bus.output_channel_ready = '0;
      repeat (2) @(negedge clock);
      checking = 1;
      check("rst_counts", 64'(bus.output_channel_counts), 64'd0);
      check("rst_valid", 64'(bus.output_channel_valid), 64'd0);
      check("rst_data", 64'(bus.output_channel_data), 64'd0);
      reset = 1'b1;

      // Idle patterns: oci without valid, valid without oci.
      step(1'b0, 4'b1111, 3'd1, 32'h1, 4'b0000);
      step(1'b1, 4'b0000, 3'd1, 32'h2, 4'b0000);
      check("noop_counts", 64'(bus.output_channel_counts), 64'd0);

      // Fill ch0 then drain in order.
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0001, 3'd0, 32'hA0 + k, 4'b0000);
      check("fill_count0", 64'(bus.output_channel_counts[0]), 64'd4);
      check("fill_head0", 64'(bus.output_channel_data[0]), 64'hA0);
      for (int k = 1; k < 4; k++) begin
         step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b0001);
         check("drain_head0", 64'(bus.output_channel_data[0]), 64'hA0 + k);
      end
      step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b0001);
      check("drain_count0", 64'(bus.output_channel_counts[0]), 64'd0);

      // Multicast into empty bank.
      step(1'b1, 4'b1011, 3'd5, 32'hDEAD, 4'b0000);
      check("mc_valid", 64'(bus.output_channel_valid), 64'b1011);
      check("mc_count2", 64'(bus.output_channel_counts[2]), 64'd0);
      check("mc_count3", 64'(bus.output_channel_counts[3]), 64'd1);
      check("mc_tag1", 64'(bus.output_channel_tags[1]), 64'd5);
      check("mc_data3", 64'(bus.output_channel_data[3]), 64'hDEAD);
      step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b1111);

      // Full ch1 with simultaneous dequeue.
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0010, 3'd1, 32'h10 + k, 4'b0000);
      step(1'b1, 4'b0010, 3'd2, 32'hBEEF, 4'b0010);
      check("full_count1", 64'(bus.output_channel_counts[1]), 64'd4);
      check("full_head1", 64'(bus.output_channel_data[1]), 64'h11);
      for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b0010);
      check("beef_4th", 64'(bus.output_channel_data[1]), 64'hBEEF);
      check("beef_tag", 64'(bus.output_channel_tags[1]), 64'd2);
      step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b0010);

      // Overflow on ch2 while ch1 accepts the same multicast word.
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0100, 3'd4, 32'h20 + k, 4'b0000);
      step(1'b1, 4'b0110, 3'd1, 32'h55, 4'b0000);
      check("ovf_count1", 64'(bus.output_channel_counts[1]), 64'd1);
      check("ovf_count2", 64'(bus.output_channel_counts[2]), 64'd4);
      check("ovf_head2", 64'(bus.output_channel_data[2]), 64'h20);
      check("ovf_flag", 64'(bus.overflow_error), 64'(OVF_EXP));
      repeat (2) step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b0000);
      repeat (4) step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b1111);
      check("ovf_sticky", 64'(bus.overflow_error), 64'(OVF_EXP));

      // Pointer wrap on ch3.
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 4'b1000, 3'd3, 32'h30 + k, 4'b1000);
         check("wrap_head3", 64'(bus.output_channel_data[3]), 64'h30 + k);
         check("wrap_count3", 64'(bus.output_channel_counts[3]), 64'd1);
      end
      step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b1000);

      // Asynchronous reset mid-traffic.
      step(1'b1, 4'b1111, 3'd2, 32'h77, 4'b0000);
      step(1'b1, 4'b1111, 3'd2, 32'h78, 4'b0000);
      bus.output_channel_ready = 4'b1111;
      #2 reset = 1'b0;
      #1;
      check("mid_counts", 64'(bus.output_channel_counts), 64'd0);
      check("mid_valid", 64'(bus.output_channel_valid), 64'd0);
      check("mid_ovf", 64'(bus.overflow_error), 64'd0);
      @(negedge clock);
      bus.enqueue_valid = 1'b0;
      reset = 1'b1;
      step(1'b1, 4'b0100, 3'd6, 32'h99, 4'b0000);
      check("post_rst_data2", 64'(bus.output_channel_data[2]), 64'h99);
      step(1'b0, 4'b0000, 3'd0, 32'h0, 4'b1111);

      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
